muldiv_unit: RTL and testbench
==============================

MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 Parameter: WIDTH, default 32, operand and result-half width; legal values are 8 to 64.
REQ-002 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-003 Port: reset  input  1  synchronous, active-high; sampled on the clk rising edge.
REQ-004 Port: start  input  1  request to begin an operation; sampled only in IDLE.
REQ-005 Port: op  input  2  operation: 00 MULTU, 01 MULT (signed), 10 DIVU, 11 DIV (signed).
REQ-006 Port: a  input  WIDTH  multiplicand or dividend.
REQ-007 Port: b  input  WIDTH  multiplier or divisor.
REQ-008 Port: busy  output  1  high while an operation is in progress.
REQ-009 Port: done  output  1  single-cycle pulse; hi and lo hold the new result in that cycle.
REQ-010 Port: hi  output  WIDTH  upper product half, or remainder.
REQ-011 Port: lo  output  WIDTH  lower product half, or quotient.
REQ-012 Port: div_by_zero  output  1  set with done when a DIVU or DIV operation had b==0; cleared on the next accepted start.

Function
REQ-013 FSM states: IDLE, RUN, FIN; busy = (state != IDLE), derived directly from the registered state.
REQ-014 IDLE with start=1 at an edge: latch op and operands, converting them to magnitudes for MULT/DIV; load iteration counter = WIDTH; go to RUN.
REQ-015 RUN: one shift-add (multiply) or restoring shift-subtract (divide) step per cycle; decrement the counter; go to FIN after exactly WIDTH steps.
REQ-016 FIN: apply sign correction, write hi and lo, assert done for one cycle, return to IDLE.
REQ-017 Latency is fixed for every op and operand: if start is sampled at edge N, hi, lo and done update at edge N+WIDTH+1, and busy is high from edge N to edge N+WIDTH+1.
REQ-018 start sampled while busy is ignored; a, b and op may change freely after acceptance without affecting the result.
REQ-019 start may be accepted at the edge that ends the done cycle, giving back-to-back operations with no idle gap.
REQ-020 MULT/MULTU: {hi,lo} = full 2*WIDTH-bit product, signed or unsigned per op.
REQ-021 DIV/DIVU: lo = quotient, hi = remainder; the signed quotient truncates toward zero and the signed remainder takes the sign of the dividend.
REQ-022 DIV with a = most-negative value and b = -1: lo = most-negative value, hi = 0, no flag.
REQ-023 Divide by zero (b==0, DIVU or DIV): latency is unchanged; lo = all ones, hi = a, div_by_zero = 1.
REQ-024 hi and lo hold their values between operations; they change only in FIN or on reset.

Reset
REQ-025 reset=1 at an edge forces state IDLE, counter 0, busy 0, done 0, div_by_zero 0, hi 0, lo 0.
REQ-026 Reset mid-operation abandons the operation; no done pulse follows, and hi and lo read 0.
REQ-027 Reset has priority over start in the same cycle; start is not accepted.

Verification (WIDTH=32)
REQ-028 MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> done 33 cycles after start; hi=0xFFFFFFFE, lo=0x00000001.
REQ-029 MULT a=-3 (0xFFFFFFFD), b=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB.
REQ-030 DIV a=-7, b=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1); DIVU a=100, b=7 -> lo=14, hi=2.
REQ-031 DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0; DIVU a=5, b=0 -> lo=0xFFFFFFFF, hi=5, div_by_zero=1 with done.
REQ-032 start pulsed mid-RUN is ignored (a single done pulse); reset at cycle 10 of a MULTU -> busy 0 next cycle, no done, hi=lo=0.
REQ-033 Back-to-back: a new start in the done cycle -> the second done arrives exactly 33 cycles later, and the first result holds until then.

Source files
------------

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative multiply/divide unit.
// One shift-add (multiply) or restoring shift-subtract (divide) step per cycle.
// Signed operations run on magnitudes, and the sign is fixed up in the final cycle.
// Latency is fixed at WIDTH+1 cycles from the accepted start to done.
//
// Handshake: start is sampled only while busy is low. An operation is accepted
// at the rising edge where start=1 and the unit is idle. busy goes high from
// that edge until the edge that raises done. done is a one-cycle pulse; hi, lo
// and div_by_zero are valid in that cycle and hold afterwards. A new start may
// be presented during the done cycle, because the unit is already idle then.
// A start presented while busy is dropped and is not queued.
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] CNT_LOAD = CW'(WIDTH);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    // FSM state; kept as a named enum so checkers can bind to it directly.
    state_t state;
    state_t state_nxt;

    logic [CW-1:0]        cnt;
    logic                 is_div_q;   // 1 = divide, 0 = multiply
    logic                 neg_q;      // product or quotient needs negation
    logic                 neg_rem_q;  // remainder needs negation (dividend sign)
    logic                 dbz_q;      // divide with b == 0
    logic [WIDTH-1:0]     a_q;        // raw dividend, returned in hi on divide by zero
    logic [WIDTH-1:0]     b_mag;      // multiplicand or divisor magnitude
    logic [2*WIDTH-1:0]   p;          // {partial product or remainder, multiplier or quotient}

    logic                 a_neg;
    logic                 b_neg;
    logic [WIDTH-1:0]     a_mag_in;
    logic [WIDTH-1:0]     b_mag_in;
    logic [WIDTH:0]       mul_sum;
    logic [2*WIDTH-1:0]   mul_step;
    logic [WIDTH:0]       div_shift;
    logic [WIDTH:0]       div_trial;
    logic [2*WIDTH-1:0]   div_step;
    logic [2*WIDTH-1:0]   p_neg;
    logic [WIDTH-1:0]     quo_neg;
    logic [WIDTH-1:0]     rem_neg;

    // Operand magnitudes for signed ops (op[0] = 1 means signed).
    always_comb begin
        a_neg    = op[0] & a[WIDTH-1];
        b_neg    = op[0] & b[WIDTH-1];
        a_mag_in = a_neg ? -a : a;
        b_mag_in = b_neg ? -b : b;
    end

    // One iteration of both datapaths, plus the negated results for sign fix-up.
    always_comb begin
        mul_sum   = {1'b0, p[2*WIDTH-1:WIDTH]} + (p[0] ? {1'b0, b_mag} : '0);
        mul_step  = {mul_sum, p[WIDTH-1:1]};
        div_shift = {p[2*WIDTH-1:WIDTH], p[WIDTH-1]};
        div_trial = div_shift - {1'b0, b_mag};
        if (div_trial[WIDTH]) begin
            div_step = {div_shift[WIDTH-1:0], p[WIDTH-2:0], 1'b0};
        end else begin
            div_step = {div_trial[WIDTH-1:0], p[WIDTH-2:0], 1'b1};
        end
        p_neg   = -p;
        quo_neg = -p[WIDTH-1:0];
        rem_neg = -p[2*WIDTH-1:WIDTH];
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: RUN lasts exactly WIDTH cycles.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (cnt == CNT_ONE) state_nxt = FIN;
            FIN:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State-derived outputs.
    always_comb begin
        busy = (state != IDLE);
    end

    // Datapath: latch on accept, iterate in RUN, publish the result in FIN.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt         <= '0;
            is_div_q    <= 1'b0;
            neg_q       <= 1'b0;
            neg_rem_q   <= 1'b0;
            dbz_q       <= 1'b0;
            a_q         <= '0;
            b_mag       <= '0;
            p           <= '0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            hi          <= '0;
            lo          <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        cnt         <= CNT_LOAD;
                        is_div_q    <= op[1];
                        neg_q       <= a_neg ^ b_neg;
                        neg_rem_q   <= a_neg;
                        dbz_q       <= op[1] & (b == '0);
                        a_q         <= a;
                        b_mag       <= b_mag_in;
                        p           <= {{WIDTH{1'b0}}, a_mag_in};
                        div_by_zero <= 1'b0;
                    end
                end
                RUN: begin
                    cnt <= cnt - CNT_ONE;
                    p   <= is_div_q ? div_step : mul_step;
                end
                FIN: begin
                    done        <= 1'b1;
                    div_by_zero <= dbz_q;
                    if (dbz_q) begin
                        hi <= a_q;
                        lo <= '1;
                    end else if (!is_div_q) begin
                        {hi, lo} <= neg_q ? p_neg : p;
                    end else begin
                        lo <= neg_q ? quo_neg : p[WIDTH-1:0];
                        hi <= neg_rem_q ? rem_neg : p[2*WIDTH-1:WIDTH];
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed and randomized checks of muldiv_unit (WIDTH=32)
// against a cycle-level behavioural model built from plain arithmetic.
module tb_muldiv_unit;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic [1:0]   op = 2'd0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         div_by_zero;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    muldiv_unit #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .busy(busy), .done(done), .hi(hi), .lo(lo), .div_by_zero(div_by_zero)
    );

    // ---------------- clock / watchdog ----------------
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- checking helper ----------------
    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference result: {div_by_zero, hi, lo} from the arithmetic definition.
    function automatic logic [2*W:0] model(input logic [1:0] o, input logic [W-1:0] x,
                                          input logic [W-1:0] y);
        longint          sx, sy;
        longint unsigned ux, uy;
        logic [2*W-1:0]  prod;
        logic [W-1:0]    q, r;
        case (o)
            2'd0: begin
                ux = x; uy = y; prod = ux * uy;
                return {1'b0, prod};
            end
            2'd1: begin
                sx = $signed(x); sy = $signed(y); prod = sx * sy;
                return {1'b0, prod};
            end
            2'd2: begin
                if (y == 0) return {1'b1, x, {W{1'b1}}};
                q = x / y; r = x % y;
                return {1'b0, r, q};
            end
            default: begin
                if (y == 0) return {1'b1, x, {W{1'b1}}};
                sx = $signed(x); sy = $signed(y);
                q = 32'(sx / sy); r = 32'(sx % sy);
                return {1'b0, r, q};
            end
        endcase
    endfunction

    // ---------------- behavioural model (cycle-level) ----------------
    logic [2*W:0] exp_q[$];
    int           m_rem  = 0;
    logic         m_busy = 1'b0;
    logic         m_done = 1'b0;
    logic [W-1:0] m_hi   = '0;
    logic [W-1:0] m_lo   = '0;
    logic         m_dbz  = 1'b0;

    always @(posedge clk) begin
        logic [2*W:0] r;
        if (reset) begin
            m_rem = 0; m_done = 1'b0; m_hi = '0; m_lo = '0; m_dbz = 1'b0;
            exp_q.delete();
        end else begin
            m_done = 1'b0;
            if (m_rem > 0) begin
                m_rem--;
                if (m_rem == 0) begin
                    if (exp_q.size() > 0) begin
                        r = exp_q.pop_front();
                        {m_dbz, m_hi, m_lo} = r;
                    end
                    m_done = 1'b1;
                end
            end else if (start) begin
                exp_q.push_back(model(op, a, b));
                m_rem = W + 1;
                m_dbz = 1'b0;
            end
        end
        m_busy = (m_rem != 0);
    end

    // ---------------- per-cycle compare ----------------
    always @(posedge clk) begin
        #1;
        if (chk_en) begin
            check("cyc_busy", busy, m_busy);
            check("cyc_done", done, m_done);
            check("cyc_hi", hi, m_hi);
            check("cyc_lo", lo, m_lo);
            check("cyc_dbz", div_by_zero, m_dbz);
        end
    end

    // ---------------- driver tasks ----------------
    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 7))
            0:       return '0;
            1:       return '1;
            2:       return 32'h8000_0000;
            3:       return 32'(1);
            default: return $urandom;
        endcase
    endfunction

    task automatic wait_done(output int n);
        n = 0;
        while (done !== 1'b1 && n < 60) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic pulse_start(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        @(negedge clk);
        start = 1'b1; op = o; a = x; b = y;
        @(negedge clk);
        start = 1'b0;
        op = 2'($urandom_range(0, 3)); a = $urandom; b = $urandom;
    endtask

    task automatic run_op(input string name, input logic [1:0] o, input logic [W-1:0] x,
                          input logic [W-1:0] y, input logic [W-1:0] ehi,
                          input logic [W-1:0] elo, input logic edbz);
        int n;
        pulse_start(o, x, y);
        wait_done(n);
        check({name, "_latency"}, n, 33);
        check({name, "_hi"}, hi, ehi);
        check({name, "_lo"}, lo, elo);
        check({name, "_dbz"}, div_by_zero, edbz);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int n;
        int pulses;
        logic [2*W:0] r1;

        // Pin the model itself with hand-computed values.
        check("model_multu", model(2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF), {1'b0, 64'hFFFF_FFFE_0000_0001});
        check("model_mult", model(2'd1, 32'hFFFF_FFFD, 32'd7), {1'b0, 64'hFFFF_FFFF_FFFF_FFEB});
        check("model_div", model(2'd3, 32'hFFFF_FFF9, 32'd2), {1'b0, 64'hFFFF_FFFF_FFFF_FFFD});
        check("model_divmin", model(2'd3, 32'h8000_0000, 32'hFFFF_FFFF), {1'b0, 64'h0000_0000_8000_0000});
        check("model_dbz", model(2'd2, 32'd5, 32'd0), {1'b1, 64'h0000_0005_FFFF_FFFF});

        // Reset.
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        chk_en = 1'b1;
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_hi", hi, 32'd0);
        check("rst_lo", lo, 32'd0);
        check("rst_dbz", div_by_zero, 1'b0);

        // Directed cases with literal expectations.
        run_op("multu_max", 2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
        run_op("mult_neg", 2'd1, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);
        run_op("div_neg", 2'd3, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
        run_op("divu", 2'd2, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0);
        run_op("div_ovf", 2'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 1'b0);
        run_op("divu_zero", 2'd2, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, 1'b1);
        run_op("div_zero", 2'd3, 32'hFFFF_FFF7, 32'd0, 32'hFFFF_FFF7, 32'hFFFF_FFFF, 1'b1);
        run_op("mult_min", 2'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'd0, 1'b0);

        // Start pulsed mid-RUN is ignored: exactly one done, first result kept.
        pulse_start(2'd0, 32'd1000, 32'd3);
        repeat (8) @(negedge clk);
        start = 1'b1; op = 2'd0; a = 32'd9; b = 32'd9;
        @(negedge clk);
        start = 1'b0;
        pulses = 0;
        for (int i = 0; i < 50; i++) begin
            if (done === 1'b1) pulses++;
            @(negedge clk);
        end
        check("midrun_pulses", pulses, 1);
        check("midrun_lo", lo, 32'd3000);
        check("midrun_hi", hi, 32'd0);

        // Reset at cycle 10 of a MULTU abandons the operation.
        pulse_start(2'd0, 32'h1234_5678, 32'h9ABC_DEF0);
        repeat (9) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort_busy", busy, 1'b0);
        check("abort_hi", hi, 32'd0);
        check("abort_lo", lo, 32'd0);
        pulses = 0;
        for (int i = 0; i < 45; i++) begin
            if (done === 1'b1) pulses++;
            @(negedge clk);
        end
        check("abort_pulses", pulses, 0);

        // Reset has priority over a simultaneous start.
        @(negedge clk);
        reset = 1'b1; start = 1'b1; op = 2'd0; a = 32'd2; b = 32'd2;
        @(negedge clk);
        reset = 1'b0; start = 1'b0;
        check("rst_prio_busy", busy, 1'b0);

        // Back-to-back: second start presented in the done cycle.
        pulse_start(2'd2, 32'd100, 32'd7);
        wait_done(n);
        check("b2b_first_latency", n, 33);
        start = 1'b1; op = 2'd1; a = 32'hFFFF_FFFE; b = 32'd5;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (done !== 1'b1 && n < 60) begin
            if (hi !== 32'd2 || lo !== 32'd14) check("b2b_hold", {hi, lo}, {32'd2, 32'd14});
            @(negedge clk);
            n++;
        end
        check("b2b_second_latency", n, 33);
        check("b2b_hi", hi, 32'hFFFF_FFFF);
        check("b2b_lo", lo, 32'hFFFF_FFF6);

        // Randomized traffic, including starts while busy and occasional resets.
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            reset = ($urandom_range(0, 599) == 0);
            start = ($urandom_range(0, 3) == 0);
            op    = 2'($urandom_range(0, 3));
            a     = pick();
            b     = pick();
        end
        @(negedge clk);
        reset = 1'b0; start = 1'b0;
        repeat (40) @(negedge clk);
        r1 = model(2'd3, 32'd7, 32'hFFFF_FFFE);
        check("model_div_negdiv", r1, {1'b0, 32'd1, 32'hFFFF_FFFD});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
